// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard unit: EX/MEM/WB destination tracking, operand
//               forwarding select, load-use stall and redirect flush.
//               Optional performance counters under macro HAZARD_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_rf1,
   input  logic             id_rf2,
   input  logic             id_we,
   input  logic             id_load,
   input  logic             id_redirect,
   output logic             stall,
   output logic             bubble,
   output logic             flush_ifid,
   output logic [1:0]       fwd_rs1,
   output logic [1:0]       fwd_rs2
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   typedef struct packed {
      logic [4:0] rd;
      logic       we;
      logic       load;
   } slot_t;

   localparam logic [1:0] c_FWD_RF  = 2'b00;
   localparam logic [1:0] c_FWD_EX  = 2'b01;
   localparam logic [1:0] c_FWD_MEM = 2'b10;
   localparam logic [1:0] c_FWD_WB  = 2'b11;

   slot_t r_ex;
   slot_t r_mem;
   slot_t r_wb;

   logic       w_ex_m1, w_mem_m1, w_wb_m1;
   logic       w_ex_m2, w_mem_m2, w_wb_m2;
   logic       w_stall;
   logic [1:0] w_fwd1, w_fwd2;

   if (CNT_W < 1) begin : g_cnt_w_check
      $error("hazard_ctrl: CNT_W must be at least 1");
   end

   function automatic logic slot_match(input slot_t s, input logic [4:0] rs, input logic rf);
      return s.we && (s.rd != 5'd0) && (s.rd == rs) && rf;
   endfunction

   function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem, input logic m_wb);
      if (m_ex)       return c_FWD_EX;
      else if (m_mem) return c_FWD_MEM;
      else if (m_wb)  return c_FWD_WB;
      else            return c_FWD_RF;
   endfunction

   always_comb begin
      w_ex_m1  = slot_match(r_ex,  id_rs1, id_rf1);
      w_mem_m1 = slot_match(r_mem, id_rs1, id_rf1);
      w_wb_m1  = slot_match(r_wb,  id_rs1, id_rf1);
      w_ex_m2  = slot_match(r_ex,  id_rs2, id_rf2);
      w_mem_m2 = slot_match(r_mem, id_rs2, id_rf2);
      w_wb_m2  = slot_match(r_wb,  id_rs2, id_rf2);
      w_fwd1   = fwd_sel(w_ex_m1, w_mem_m1, w_wb_m1);
      w_fwd2   = fwd_sel(w_ex_m2, w_mem_m2, w_wb_m2);
      w_stall  = (w_ex_m1 || w_ex_m2) && r_ex.load;
   end

   // Reset masks the slot-derived outputs so a stale slot cannot stall or forward.
   always_comb begin
      stall      = 1'b0;
      fwd_rs1    = c_FWD_RF;
      fwd_rs2    = c_FWD_RF;
      if (!rst) begin
         stall   = w_stall;
         fwd_rs1 = w_fwd1;
         fwd_rs2 = w_fwd2;
      end
      bubble     = stall;
      flush_ifid = id_redirect && !stall;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex  <= '0;
         r_mem <= '0;
         r_wb  <= '0;
      end else begin
         r_wb  <= r_mem;
         r_mem <= r_ex;
         if (bubble) begin
            r_ex <= '0;
         end else begin
            r_ex <= '{rd: id_rd, we: id_we, load: id_load};
         end
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stall) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (flush_ifid) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Randomized plus directed bench for hazard_ctrl against a
//               producer-distance reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       id_rs1, id_rs2, id_rd;
   logic             id_rf1, id_rf2, id_we, id_load, id_redirect;
   logic             stall, bubble, flush_ifid;
   logic [1:0]       fwd_rs1, fwd_rs2;
`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   // Reference: list of in-flight instructions, index 0 youngest (in EX).
   int m_rd [3];
   bit m_we [3];
   bit m_ld [3];
   longint unsigned m_scnt = 0;
   longint unsigned m_fcnt = 0;

   // Outputs seen by the most recent step
   logic       o_stall, o_flush;
   logic [1:0] o_f1, o_f2;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(CNT_W)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rd       (id_rd),
      .id_rf1      (id_rf1),
      .id_rf2      (id_rf2),
      .id_we       (id_we),
      .id_load     (id_load),
      .id_redirect (id_redirect),
      .stall       (stall),
      .bubble      (bubble),
      .flush_ifid  (flush_ifid),
      .fwd_rs1     (fwd_rs1),
      .fwd_rs2     (fwd_rs2)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Distance (1 = EX, 2 = MEM, 3 = WB) of the youngest in-flight writer of rs, 0 if none.
   function automatic int producer(input int rs, input bit rf);
      if (!rf || rs == 0) return 0;
      for (int d = 0; d < 3; d++)
         if (m_we[d] && m_rd[d] == rs) return d + 1;
      return 0;
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 3; d++) begin
         m_rd[d] = 0; m_we[d] = 0; m_ld[d] = 0;
      end
      m_scnt = 0;
      m_fcnt = 0;
   endtask

   task automatic step(input bit r, input int rs1, input int rs2, input int rd,
                       input bit rf1, input bit rf2, input bit we, input bit ld, input bit redir);
      int  p1, p2;
      bit  e_stall, e_flush;
      @(posedge clk);
      #1;
      rst = r; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
      id_rf1 = rf1; id_rf2 = rf2; id_we = we; id_load = ld; id_redirect = redir;
      #3;
      p1 = r ? 0 : producer(rs1, rf1);
      p2 = r ? 0 : producer(rs2, rf2);
      e_stall = !r && m_ld[0] && (p1 == 1 || p2 == 1);
      e_flush = redir && !e_stall;
      chk("stall",  64'(stall),      64'(e_stall));
      chk("bubble", 64'(bubble),     64'(e_stall));
      chk("flush",  64'(flush_ifid), 64'(e_flush));
      chk("fwd1",   64'(fwd_rs1),    64'(p1));
      chk("fwd2",   64'(fwd_rs2),    64'(p2));
`ifdef HAZARD_PERF_EN
      chk("scnt", 64'(stall_cnt), 64'(m_scnt % (64'd1 << CNT_W)));
      chk("fcnt", 64'(flush_cnt), 64'(m_fcnt % (64'd1 << CNT_W)));
`endif
      o_stall = stall; o_flush = flush_ifid; o_f1 = fwd_rs1; o_f2 = fwd_rs2;
      // Advance the model to what follows the coming edge
      if (r) begin
         model_clear();
      end else begin
         for (int d = 2; d > 0; d--) begin
            m_rd[d] = m_rd[d-1]; m_we[d] = m_we[d-1]; m_ld[d] = m_ld[d-1];
         end
         m_rd[0] = e_stall ? 0 : rd;
         m_we[0] = e_stall ? 0 : we;
         m_ld[0] = e_stall ? 0 : ld;
         if (e_stall) m_scnt++;
         if (e_flush) m_fcnt++;
      end
   endtask

   task automatic nop(); step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

   initial begin
      rst = 1; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rf1 = 0; id_rf2 = 0;
      id_we = 0; id_load = 0; id_redirect = 0;
      model_clear();

      // Reset state: outputs masked, flush follows redirect
      step(1, 1, 1, 1, 1, 1, 1, 1, 1);
      chk("rst_flush", 64'(o_flush), 64'd1);
      nop(); nop(); nop();

      // Load-use: lw x5 ; add x6,x5,x7 -> one stall cycle, then MEM forward
      step(0, 0, 0, 5, 0, 0, 1, 1, 0);
      step(0, 5, 7, 6, 1, 1, 1, 0, 0);
      chk("lu_stall", 64'(o_stall), 64'd1);
      step(0, 5, 7, 6, 1, 1, 1, 0, 0);
      chk("lu_stall_clear", 64'(o_stall), 64'd0);
      chk("lu_fwd_mem", 64'(o_f1), 64'd2);
      nop(); nop(); nop();

      // ALU chain: add x3 ; beq x3,x3
      step(0, 0, 0, 3, 0, 0, 1, 0, 0);
      step(0, 3, 3, 0, 1, 1, 0, 0, 1);
      chk("alu_fwd1", 64'(o_f1), 64'd1);
      chk("alu_fwd2", 64'(o_f2), 64'd1);
      chk("alu_nostall", 64'(o_stall), 64'd0);
      nop(); nop(); nop();

      // Priority: x4 in WB and EX, ID reads x4 on rs2; then rs1/rs2 in different slots
      step(0, 0, 0, 4, 0, 0, 1, 0, 0);
      step(0, 0, 0, 9, 0, 0, 1, 0, 0);
      step(0, 0, 0, 4, 0, 0, 1, 0, 0);
      step(0, 9, 4, 1, 1, 1, 1, 0, 0);
      chk("prio_fwd2", 64'(o_f2), 64'd1);
      chk("prio_fwd1_mem", 64'(o_f1), 64'd2);
      nop(); nop(); nop();

      // x0 destination never matches
      step(0, 0, 0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 2, 1, 1, 1, 0, 0);
      chk("x0_fwd1", 64'(o_f1), 64'd0);
      chk("x0_nostall", 64'(o_stall), 64'd0);

      // Redirect under stall, counters from a clean reset
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 5, 0, 0, 1, 1, 0);
      step(0, 5, 0, 6, 1, 0, 1, 0, 1);
      chk("redir_flush_stall", 64'(o_flush), 64'd0);
      step(0, 5, 0, 6, 1, 0, 1, 0, 1);
      chk("redir_flush_after", 64'(o_flush), 64'd1);
      nop();
`ifdef HAZARD_PERF_EN
      chk("redir_fcnt", 64'(flush_cnt), 64'd1);
`endif

      // Reset while a load sits in EX
      step(0, 0, 0, 8, 0, 0, 1, 1, 0);
      step(1, 8, 8, 0, 1, 1, 0, 0, 0);
      step(0, 8, 8, 0, 1, 1, 0, 0, 0);
      chk("rst_mid_stall", 64'(o_stall), 64'd0);
      chk("rst_fwd1", 64'(o_f1), 64'd0);
      chk("rst_fwd2", 64'(o_f2), 64'd0);
`ifdef HAZARD_PERF_EN
      chk("rst_scnt", 64'(stall_cnt), 64'd0);
`endif

      // Randomized traffic over a small register window to provoke hazards
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 39) == 0,
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
